// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double-buffered framebuffer.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 400;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    // Pixel word; bit 0 carries transparency and is stored as-is.
    typedef logic [15:0] color_t;

    // Buffer-swap controller states.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/fb_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no content reset.
module fb_dual_port_ram #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer.sv
// Double-buffered pixel store: GPU writes to the back buffer, scan-out reads
// the front buffer, and buffers exchange only during vertical blank.
module framebuffer
    import fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(FB_WIDTH):0]  fb_x,
    input  logic [$clog2(FB_HEIGHT):0] fb_y,
    input  logic [15:0]                fb_color,
    input  logic                       fb_write,
    input  logic                       rd_en,
    input  logic [$clog2(FB_WIDTH):0]  rd_x,
    input  logic [$clog2(FB_HEIGHT):0] rd_y,
    output logic [15:0]                rd_color,
    output logic                       rd_valid,
    input  logic                       vblank,
    input  logic                       swap_req,
    output logic                       swap_pending,
    output logic                       swap_done,
    output logic                       front_sel
);

    localparam int unsigned NPIX  = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned DEPTH = 2 * NPIX;
    localparam int unsigned AW    = $clog2(DEPTH);

    swap_state_e state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        swap_done_q, swap_done_d;
    logic        swap_req_q;
    logic        swap_rise_c;

    logic        wr_buf_c;
    logic        wr_inb_c, rd_inb_c;
    logic [31:0] wr_lin_c, rd_lin_c;
    logic        unused_addr_hi;

    color_t      ram_rdata;
    logic        rd_vld1_q, rd_inb1_q;
    color_t      rd_color_q;
    logic        rd_valid_q;

    // Bounds checks and linear address generation; buffer chosen from the
    // front_sel value at request time so swap-edge accesses use the old mapping.
    assign wr_buf_c = ~front_sel_q;
    assign wr_inb_c = (32'(fb_x) < FB_WIDTH) && (32'(fb_y) < FB_HEIGHT);
    assign rd_inb_c = (32'(rd_x) < FB_WIDTH) && (32'(rd_y) < FB_HEIGHT);
    assign wr_lin_c = 32'(wr_buf_c) * NPIX + 32'(fb_y) * FB_WIDTH + 32'(fb_x);
    assign rd_lin_c = 32'(front_sel_q) * NPIX + 32'(rd_y) * FB_WIDTH + 32'(rd_x);
    assign unused_addr_hi = ^{wr_lin_c[31:AW], rd_lin_c[31:AW]};

    fb_dual_port_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(color_t))
    ) u_ram (
        .clk     (clk),
        .we_i    (fb_write & wr_inb_c),
        .waddr_i (AW'(wr_lin_c)),
        .wdata_i (fb_color),
        .re_i    (rd_en & rd_inb_c),
        .raddr_i (AW'(rd_lin_c)),
        .rdata_o (ram_rdata)
    );

    // Read pipeline: stage 1 tracks the RAM access, stage 2 is the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld1_q  <= 1'b0;
            rd_inb1_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_color_q <= '0;
        end else begin
            rd_vld1_q  <= rd_en;
            rd_inb1_q  <= rd_inb_c;
            rd_valid_q <= rd_vld1_q;
            if (rd_vld1_q) begin
                rd_color_q <= rd_inb1_q ? ram_rdata : '0;
            end
        end
    end

    assign swap_rise_c = swap_req & ~swap_req_q;

    // Swap controller state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            swap_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            swap_req_q  <= swap_req;
        end
    end

    // Swap controller next state: arm on a request edge, exchange in vblank.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_rise_c) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (vblank) begin
                    state_d     = IDLE;
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_color     = rd_color_q;
    assign rd_valid     = rd_valid_q;
    assign swap_pending = (state_q == PENDING);
    assign swap_done    = swap_done_q;
    assign front_sel    = front_sel_q;

endmodule
